// File: rtl/seq_multi_pkg.sv
// Shared constants for the sequential shift-add multiplier.
package seq_multi_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  // Row counter width for a given operand width (WIDTH >= 2).
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_multi_if.sv
// Operand/result valid-ready bus of the sequential multiplier.
interface seq_multi_if #(
  parameter int unsigned WIDTH = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] Mult_out;

  modport master (
    output in_valid, A, B, signed_mode, out_ready,
    input  in_ready, out_valid, Mult_out
  );

  modport slave (
    input  in_valid, A, B, signed_mode, out_ready,
    output in_ready, out_valid, Mult_out
  );

endinterface

// File: rtl/add_nbit.sv
// N-bit ripple-carry adder from fa cells; result is modulo 2^N.
module add_nbit #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);

  logic [N-1:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N - 1; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // MSB carry-out is discarded, so the top bit needs only the sum term.
  assign sum[N-1] = a[N-1] ^ b[N-1] ^ carry[N-1];

endmodule

// File: rtl/fa.sv
// One-bit full-adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_multi_nbit.sv
// Sequential WIDTH x WIDTH multiplier: one partial-product row per clock,
// sign handled as magnitude multiply plus final conditional negation.
module seq_multi_nbit
  import seq_multi_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_multi_if.slave  bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mult_q, mult_d;
  logic             in_ready_q, out_valid_q;

  logic [PW-1:0]    row;
  logic [PW-1:0]    row_sum;
  logic [PW-1:0]    fin_in;
  logic [PW-1:0]    fin_sum;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  assign a_mag = (bus.signed_mode && bus.A[WIDTH-1]) ? (~bus.A + WIDTH'(1)) : bus.A;
  assign b_mag = (bus.signed_mode && bus.B[WIDTH-1]) ? (~bus.B + WIDTH'(1)) : bus.B;

  assign row = areg_q[cnt_q] ? (PW'(breg_q) << cnt_q) : '0;

  add_nbit #(.N(PW)) u_row_add (
    .a   (acc_q),
    .b   (row),
    .cin (1'b0),
    .sum (row_sum)
  );

  // Two's-complement negation as invert plus one.
  assign fin_in = neg_q ? ~row_sum : row_sum;

  add_nbit #(.N(PW)) u_neg_add (
    .a   (fin_in),
    .b   (PW'(0)),
    .cin (neg_q),
    .sum (fin_sum)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    mult_d  = mult_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          areg_d  = a_mag;
          breg_d  = b_mag;
          neg_d   = bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d = row_sum;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          mult_d  = fin_sum;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      areg_q      <= '0;
      breg_q      <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      mult_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      areg_q      <= areg_d;
      breg_q      <= breg_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      mult_q      <= mult_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Mult_out  = mult_q;

endmodule

// File: tb/tb_seq_multi_nbit.sv
// Directed and random checks of seq_multi_nbit at WIDTH=4 and WIDTH=8.
module tb_seq_multi_nbit;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_bad;

  seq_multi_if #(.WIDTH(4)) if4 ();
  seq_multi_if #(.WIDTH(8)) if8 ();

  seq_multi_nbit #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  seq_multi_nbit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=4 transaction; bp adds per-cycle checks and ignored in_valid pulses while stalled.
  task automatic do4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                     input int stall, input bit bp,
                     output logic [7:0] res, output int lat);
    int k;
    @(negedge clk);
    if4.A = a; if4.B = b; if4.signed_mode = sm; if4.in_valid = 1'b1;
    k = 0;
    while (!if4.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) chk("accept_timeout4", 64'(k), 64'(0));
    @(posedge clk);
    #1 if4.in_valid = 1'b0;
    lat = 0;
    while (!if4.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!if4.out_valid) chk("result_timeout4", 64'(if4.out_valid), 64'(1));
    res = if4.Mult_out;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (bp) begin
        if4.in_valid = 1'b1; if4.A = ~a; if4.B = ~b;
      end
      @(posedge clk);
      #1;
      if (bp) begin
        chk("bp_out_valid", 64'(if4.out_valid), 64'(1));
        chk("bp_mult_out", 64'(if4.Mult_out), 64'(res));
        chk("bp_in_ready", 64'(if4.in_ready), 64'(0));
      end
      if4.in_valid = 1'b0;
    end
    @(negedge clk);
    if4.out_ready = 1'b1;
    @(posedge clk);
    #1 if4.out_ready = 1'b0;
  endtask

  task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                     output logic [15:0] res, output int lat);
    int k;
    @(negedge clk);
    if8.A = a; if8.B = b; if8.signed_mode = sm; if8.in_valid = 1'b1;
    k = 0;
    while (!if8.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) chk("accept_timeout8", 64'(k), 64'(0));
    @(posedge clk);
    #1 if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!if8.out_valid) chk("result_timeout8", 64'(if8.out_valid), 64'(1));
    res = if8.Mult_out;
    @(negedge clk);
    if8.out_ready = 1'b1;
    @(posedge clk);
    #1 if8.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  r4;
    logic [15:0] r8;
    logic [3:0]  ra, rb;
    logic        rs;
    logic signed [7:0] sa, sb;
    logic [7:0]  exp4;
    int lat;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    if4.in_valid = 1'b0; if4.A = '0; if4.B = '0; if4.signed_mode = 1'b0; if4.out_ready = 1'b0;
    if8.in_valid = 1'b0; if8.A = '0; if8.B = '0; if8.signed_mode = 1'b0; if8.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 64'(if4.in_ready), 64'(1));
    chk("rst_out_valid", 64'(if4.out_valid), 64'(0));
    chk("rst_mult_out", 64'(if4.Mult_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do4(4'd15, 4'd15, 1'b0, 0, 1'b0, r4, lat);
    chk("u15x15", 64'(r4), 64'h0E1);
    chk("u15x15_lat", 64'(lat), 64'(4));
    #1;
    chk("post_ack_out_valid", 64'(if4.out_valid), 64'(0));
    chk("post_ack_in_ready", 64'(if4.in_ready), 64'(1));
    chk("post_ack_hold", 64'(if4.Mult_out), 64'h0E1);

    do4(4'd0, 4'd9, 1'b0, 0, 1'b0, r4, lat);
    chk("u0x9", 64'(r4), 64'h00);
    do4(4'b1000, 4'b1000, 1'b1, 1, 1'b0, r4, lat);
    chk("s-8x-8", 64'(r4), 64'h40);
    do4(4'b1101, 4'd5, 1'b1, 0, 1'b0, r4, lat);
    chk("s-3x5", 64'(r4), 64'hF1);
    do4(4'd7, 4'b1000, 1'b1, 2, 1'b0, r4, lat);
    chk("s7x-8", 64'(r4), 64'hC8);
    chk("s7x-8_lat", 64'(lat), 64'(4));

    // Ten stalled DONE cycles with operand pulses that must be ignored.
    do4(4'd6, 4'd7, 1'b0, 10, 1'b1, r4, lat);
    chk("bp_result", 64'(r4), 64'h2A);

    // Reset during row 2 of an in-flight product.
    @(negedge clk);
    if4.A = 4'd13; if4.B = 4'd11; if4.signed_mode = 1'b0; if4.in_valid = 1'b1;
    @(posedge clk);
    #1 if4.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(if4.in_ready), 64'(1));
    chk("midrst_out_valid", 64'(if4.out_valid), 64'(0));
    chk("midrst_mult_out", 64'(if4.Mult_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do4(4'd3, 4'd4, 1'b0, 0, 1'b0, r4, lat);
    chk("after_rst_3x4", 64'(r4), 64'h0C);
    chk("after_rst_lat", 64'(lat), 64'(4));

    do8(8'd255, 8'd255, 1'b0, r8, lat);
    chk("w8_u255x255", 64'(r8), 64'hFE01);
    chk("w8_lat", 64'(lat), 64'(8));
    do8(8'h80, 8'h80, 1'b1, r8, lat);
    chk("w8_s-128x-128", 64'(r8), 64'h4000);
    do8(8'hFF, 8'd2, 1'b1, r8, lat);
    chk("w8_s-1x2", 64'(r8), 64'hFFFE);

    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rs = 1'($urandom);
      sa = rs ? 8'($signed(ra)) : 8'(ra);
      sb = rs ? 8'($signed(rb)) : 8'(rb);
      exp4 = 8'(sa * sb);
      do4(ra, rb, rs, int'($urandom_range(0, 3)), 1'b0, r4, lat);
      chk("random", 64'(r4), 64'(exp4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_multi_nbit.md
# seq_multi_nbit

Parametrised sequential multiplier: the registered, handshaked successor to the 4-bit combinational array multiplier. It has configurable operand width and a run-time unsigned/two's-complement mode. It processes one partial-product row per clock through a shared ripple adder, trading latency for area. It sits between operand-producing logic and downstream consumers using valid/ready on both sides.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands A/B/signed_mode valid
- in_ready  out  1  block can accept operands; high only in IDLE
- A  in  WIDTH  multiplicand row selector (row i uses A[i])
- B  in  WIDTH  multiplicand
- signed_mode  in  1  1 = A, B and Mult_out are two's complement; 0 = unsigned
- out_valid  out  1  Mult_out holds a new result
- out_ready  in  1  consumer accepts result
- Mult_out  out  2*WIDTH  product

## Operation
- The design has one clock and one reset: clk, plus rst_n (asynchronous, active-low).
- State machine states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture the operands and go to BUSY with row counter = 0 and accumulator = 0.
  - In signed mode, capture the magnitudes |A| and |B| in WIDTH bits, treated as unsigned. This holds for -2^(WIDTH-1) too.
  - Also register neg = A[MSB]^B[MSB]. In unsigned mode, neg = 0.
- BUSY, row i:
  - acc <= acc + (Areg[i] ? (Breg << i) : 0), computed in 2*WIDTH bits.
  - Counter increments each cycle.
  - After row WIDTH-1: Mult_out <= neg ? -(acc+row) : (acc+row), mod 2^(2*WIDTH), and go to DONE.
- DONE:
  - out_valid=1; Mult_out stays stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE; the block does not accept a new operand in the same cycle as the result handshake.
- Width rules:
  - An unsigned product always fits in 2*WIDTH bits.
  - A signed product fits in 2*WIDTH signed bits, including (-2^(W-1))^2 = 2^(2W-2).
  - No overflow flag is needed.
- Inputs are ignored while the block is not in IDLE. Mult_out keeps the last result after its handshake until the next result is written.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, Mult_out=0, accumulator and counter 0.
- Reset is asynchronous and takes effect mid-operation: any in-flight product is discarded and nothing is emitted for it.
- Latency: with acceptance at rising edge t, out_valid is high after edge t+WIDTH.
- Throughput: at best one product every WIDTH+2 cycles (accept, WIDTH rows, DONE handshake cycle).
- in_ready is a registered decode of state, with no combinational path from out_ready. out_valid has no combinational path from in_valid.
- When out_ready is held low, DONE persists indefinitely and Mult_out must not change.
- out_ready sampled while out_valid=0 has no effect.

## Structure
- Shared package seq_multi_pkg:
  - state enum (IDLE, BUSY, DONE)
  - localparam CNT_W = $clog2(WIDTH)
- One sub-module, add_nbit: a parametrised 2*WIDTH-bit ripple-carry adder built from the existing FA full-adder cell.
  - One instance does the row accumulation.
  - The final conditional negation is invert-plus-one, using the same adder or a second add_nbit instance.
- Everything else (row counter, operand and accumulator registers, FSM) is inline in seq_multi_nbit.

## Test plan
- WIDTH=4, unsigned, A=15, B=15: Mult_out=0xE1 (225), out_valid exactly 4 cycles after acceptance. A=0, B=9: result 0x00.
- WIDTH=4, signed:
  - A=-8, B=-8: 0x40 (64).
  - A=-3, B=5: 0xF1 (-15).
  - A=7, B=-8: 0xC8 (-56).
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_valid and Mult_out must stay stable, and in_ready must stay 0. New in_valid pulses during that time are ignored.
- Reset mid-BUSY: assert rst_n=0 at row 2. Outputs return immediately to their reset values. The next transaction (A=3, B=4, unsigned) gives 0x0C with no residue from the aborted operation.
- WIDTH=8:
  - Unsigned 255*255 gives 0xFE01.
  - Signed -128*-128 gives 0x4000.
- Run 1000 random operand/mode pairs with random out_ready stalls, checked against a behavioural multiplier.
